// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller and the PWM peripheral:
// register map, frame geometry and controller state encoding.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;
    localparam int CNT_W      = 5;
    // One past a full frame, so over-long frames stay distinguishable.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic frame_ok(
        input logic [CNT_W-1:0]      cnt,
        input logic [FRAME_BITS-1:0] frame,
        input logic [6:0]            max_addr
    );
        return (cnt == CNT_W'(FRAME_BITS)) && frame[15] && (frame[14:8] <= max_addr);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a history flop
// that turns the synchronised level into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            hist_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~hist_reg;
    assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_reg_config.sv
// Write-only SPI (mode 0) register controller: shifts 16-bit frames in from
// synchronised pins and commits validated writes into five control registers.
module spi_reg_config
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .pin(copi),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .pin(ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Only the copi level and the sclk/ncs edges drive the controller.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

    state_t                  state_reg, state_next;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    clear_en, shift_en, commit_en;
    logic [NUM_REGS-1:0][7:0] cfg_reg;
    logic                    wr_strobe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ncs_fall) state_next = SHIFT;
            SHIFT:   if (ncs_rise) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A coincident ncs rise masks the sclk edge: the frame is closed first.
    always_comb begin
        clear_en  = 1'b0;
        shift_en  = 1'b0;
        commit_en = 1'b0;
        case (state_reg)
            IDLE:    clear_en  = ncs_fall;
            SHIFT:   shift_en  = sclk_rise && !ncs_rise;
            COMMIT:  commit_en = frame_ok(bit_cnt_reg, shift_reg, MAX_ADDR);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (clear_en) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
            if (bit_cnt_reg != CNT_SAT) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg       <= '0;
            wr_strobe_reg <= 1'b0;
        end else begin
            wr_strobe_reg <= commit_en;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_en && (shift_reg[14:8] == 7'(i))) begin
                    cfg_reg[i] <= shift_reg[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = cfg_reg[int'(ADDR_EN_OUT_LO)];
    assign en_reg_out_15_8 = cfg_reg[int'(ADDR_EN_OUT_HI)];
    assign en_reg_pwm_7_0  = cfg_reg[int'(ADDR_EN_PWM_LO)];
    assign en_reg_pwm_15_8 = cfg_reg[int'(ADDR_EN_PWM_HI)];
    assign pwm_duty_cycle  = cfg_reg[int'(ADDR_PWM_DUTY)];
    assign wr_strobe       = wr_strobe_reg;

endmodule
